dual_issue_buffer: RTL and testbench

//  Fetch-to-decode instruction queue for the dual-issue core; drives decode's instruction1/instruction2 slot pair.

---
 rtl/dual_issue_pkg.sv | 60 ++++++
 rtl/dual_issue_buffer_issue_pair_check.sv | 28 ++
 rtl/dual_issue_buffer.sv | 129 ++++++++++++
 tb/tb_dual_issue_buffer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_pkg.sv
// Shared decode helpers for the fetch-to-decode issue queue.
package dual_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [31:0] NOP = 32'h0;

  // One queue slot: instruction word and its PC.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } q_entry_t;

  function automatic logic is_ctrl(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_JAL) ||
           ((op == OP_RTYPE) && (i[5:0] == FN_JR));
  endfunction

  function automatic logic is_mem(input logic [31:0] i);
    return (i[31:26] == OP_LW) || (i[31:26] == OP_SW);
  endfunction

  // Architectural register written by i; 0 when nothing is written.
  function automatic logic [4:0] dest_reg(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    case (op)
      OP_RTYPE: return (i[5:0] == FN_JR) ? 5'd0 : i[15:11];
      OP_JAL:   return 5'd31;
      OP_LW, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: return i[20:16];
      default:  return 5'd0;
    endcase
  endfunction

  // rt is a source operand (rs is always treated as one).
  function automatic logic reads_rt(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/dual_issue_buffer_issue_pair_check.sv
// Decides whether the two oldest queued instructions can go to decode together.
module issue_pair_check
  import dual_issue_pkg::*;
(
  input  logic [31:0] h0,
  input  logic [31:0] h1,
  input  logic        h0_present,
  input  logic        h1_present,
  output logic        pair_ok
);

  logic [4:0] d0;
  logic       raw;
  logic       waw;

  // Slot 2 must not depend on or overwrite slot 1's result, and a
  // control transfer or a second memory op always forces single issue.
  always_comb begin
    d0      = dest_reg(h0);
    raw     = (d0 == h1[25:21]) || (reads_rt(h1) && (d0 == h1[20:16]));
    waw     = (d0 == dest_reg(h1));
    pair_ok = h0_present && h1_present &&
              !is_ctrl(h0) && !is_ctrl(h1) &&
              !(is_mem(h0) && is_mem(h1)) &&
              (d0 != 5'd0) && !raw && !waw;
  end

endmodule

// File: rtl/dual_issue_buffer.sv
// Circular fetch queue feeding the decode slot pair, two in / up to two out.
module dual_issue_buffer
  import dual_issue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        in_valid1,
  input  logic        in_valid2,
  input  logic [31:0] in_instr1,
  input  logic [31:0] in_instr2,
  input  logic [31:0] in_pc1,
  output logic        in_ready,
  output logic [31:0] instruction1,
  output logic [31:0] instruction2,
  output logic [31:0] pc1,
  output logic [31:0] pc2,
  output logic        issue_valid1,
  output logic        issue_valid2
);

  localparam logic [PTR_W:0] CNT_ZERO  = '0;
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO   = (PTR_W+1)'(2);
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  q_entry_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic [PTR_W:0]   wr_n, iss_n;
  logic             wr_en, wr_two;
  logic             h0_present, h1_present, pair_ok;
  logic             do_issue, issue_pair, issue_single;
  q_entry_t         h0, h1;

  assign h0 = mem[rd_ptr];
  assign h1 = mem[rd_ptr + PTR_W'(1)];

  assign h0_present = (count != CNT_ZERO);
  assign h1_present = (count >= CNT_TWO);

  issue_pair_check u_pair_check (
    .h0         (h0.instr),
    .h1         (h1.instr),
    .h0_present (h0_present),
    .h1_present (h1_present),
    .pair_ok    (pair_ok)
  );

  // Write/issue decisions and the net occupancy change for this cycle.
  always_comb begin
    wr_en        = in_ready && in_valid1 && !flush;
    wr_two       = wr_en && in_valid2;
    do_issue     = !stall && !flush;
    issue_pair   = do_issue && pair_ok;
    issue_single = do_issue && !pair_ok && h0_present;
    wr_n         = wr_two ? CNT_TWO : (wr_en ? CNT_ONE : CNT_ZERO);
    iss_n        = issue_pair ? CNT_TWO : (issue_single ? CNT_ONE : CNT_ZERO);
    count_nxt    = flush ? CNT_ZERO : (count + wr_n - iss_n);
  end

  // Queue storage; holds no control state so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en)  mem[wr_ptr]              <= '{instr: in_instr1, pc: in_pc1};
    if (wr_two) mem[wr_ptr + PTR_W'(1)]  <= '{instr: in_instr2, pc: in_pc1 + 32'd4};
  end

  // Pointers, occupancy and the registered ready; flush snaps head to tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr + wr_n[PTR_W-1:0];
      rd_ptr   <= flush ? wr_ptr : (rd_ptr + iss_n[PTR_W-1:0]);
      count    <= count_nxt;
      in_ready <= (count_nxt <= READY_MAX);
    end
  end

  // Decode slot registers: flush clears, stall holds, otherwise pair/single/empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction1 <= NOP;
      instruction2 <= NOP;
      pc1          <= '0;
      pc2          <= '0;
      issue_valid1 <= 1'b0;
      issue_valid2 <= 1'b0;
    end else if (flush) begin
      instruction1 <= NOP;
      instruction2 <= NOP;
      pc1          <= '0;
      pc2          <= '0;
      issue_valid1 <= 1'b0;
      issue_valid2 <= 1'b0;
    end else if (!stall) begin
      if (issue_pair) begin
        instruction1 <= h0.instr;
        instruction2 <= h1.instr;
        pc1          <= h0.pc;
        pc2          <= h1.pc;
        issue_valid1 <= 1'b1;
        issue_valid2 <= 1'b1;
      end else if (issue_single) begin
        instruction1 <= h0.instr;
        instruction2 <= NOP;
        pc1          <= h0.pc;
        pc2          <= '0;
        issue_valid1 <= 1'b1;
        issue_valid2 <= 1'b0;
      end else begin
        instruction1 <= NOP;
        instruction2 <= NOP;
        pc1          <= '0;
        pc2          <= '0;
        issue_valid1 <= 1'b0;
        issue_valid2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_buffer.sv
// Directed bench for the dual-issue fetch queue.
module tb_dual_issue_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, stall, in_valid1, in_valid2;
  logic [31:0] in_instr1, in_instr2, in_pc1;
  logic        in_ready, issue_valid1, issue_valid2;
  logic [31:0] instruction1, instruction2, pc1, pc2;

  int checks   = 0;
  int failures = 0;

  // Hand-encoded MIPS words
  localparam logic [31:0] ADD1 = 32'h00430820; // add $1,$2,$3
  localparam logic [31:0] ADD2 = 32'h00A62020; // add $4,$5,$6
  localparam logic [31:0] SUB  = 32'h00252022; // sub $4,$1,$5
  localparam logic [31:0] BEQ  = 32'h10220004; // beq $1,$2,4
  localparam logic [31:0] LW   = 32'h8D280000; // lw  $8,0($9)
  localparam logic [31:0] SW   = 32'hAD6A0004; // sw  $10,4($11)

  dual_issue_buffer #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid1(in_valid1), .in_valid2(in_valid2),
    .in_instr1(in_instr1), .in_instr2(in_instr2), .in_pc1(in_pc1),
    .in_ready(in_ready),
    .instruction1(instruction1), .instruction2(instruction2),
    .pc1(pc1), .pc2(pc2),
    .issue_valid1(issue_valid1), .issue_valid2(issue_valid2)
  );

  always #5 clk = ~clk;

  // add $r,$0,$0
  function automatic logic [31:0] addr(input logic [4:0] r);
    return {16'h0000, r, 11'h020};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr2(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    in_valid1 = 1'b1; in_valid2 = 1'b1; in_instr1 = a; in_instr2 = b; in_pc1 = pc;
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] pc);
    in_valid1 = 1'b1; in_valid2 = 1'b0; in_instr1 = a; in_instr2 = 32'h0; in_pc1 = pc;
  endtask

  task automatic idle();
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_instr1 = 32'h0; in_instr2 = 32'h0; in_pc1 = 32'h0;
  endtask

  task automatic chk_nop(input string tag);
    chk1 ({tag, "_v1"}, issue_valid1, 1'b0);
    chk1 ({tag, "_v2"}, issue_valid2, 1'b0);
    chk32({tag, "_i1"}, instruction1, 32'h0);
    chk32({tag, "_i2"}, instruction2, 32'h0);
    chk32({tag, "_pc1"}, pc1, 32'h0);
    chk32({tag, "_pc2"}, pc2, 32'h0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
    idle();
    #12;
    chk_nop("reset");
    chk1("reset_ready", in_ready, 1'b1);
    rst = 1'b1;

    // 1: independent pair, issued one edge after the write
    wr2(ADD1, ADD2, 32'h100);
    step(); idle();
    chk1("t1_lat_v1", issue_valid1, 1'b0);
    step();
    chk1 ("t1_v1", issue_valid1, 1'b1);
    chk1 ("t1_v2", issue_valid2, 1'b1);
    chk32("t1_i1", instruction1, ADD1);
    chk32("t1_i2", instruction2, ADD2);
    chk32("t1_pc1", pc1, 32'h100);
    chk32("t1_pc2", pc2, 32'h104);
    step();
    chk1("t1_drain_v1", issue_valid1, 1'b0);

    // 2: RAW dependence forces single issue
    wr2(ADD1, SUB, 32'h200);
    step(); idle();
    step();
    chk1 ("t2a_v1", issue_valid1, 1'b1);
    chk32("t2a_i1", instruction1, ADD1);
    chk1 ("t2a_v2", issue_valid2, 1'b0);
    chk32("t2a_i2", instruction2, 32'h0);
    chk32("t2a_pc2", pc2, 32'h0);
    step();
    chk32("t2b_i1", instruction1, SUB);
    chk32("t2b_pc1", pc1, 32'h204);
    chk1 ("t2b_v2", issue_valid2, 1'b0);
    step();

    // 3: branch alone, then two memory ops serialized
    wr2(BEQ, ADD2, 32'h300);
    step(); idle();
    step();
    chk32("t3_beq_i1", instruction1, BEQ);
    chk1 ("t3_beq_v2", issue_valid2, 1'b0);
    step();
    chk32("t3_add_i1", instruction1, ADD2);
    chk32("t3_add_pc1", pc1, 32'h304);
    chk1 ("t3_add_v2", issue_valid2, 1'b0);
    wr2(LW, SW, 32'h400);
    step(); idle();
    step();
    chk32("t3_lw_i1", instruction1, LW);
    chk1 ("t3_lw_v2", issue_valid2, 1'b0);
    step();
    chk32("t3_sw_i1", instruction1, SW);
    chk32("t3_sw_pc1", pc1, 32'h404);
    chk1 ("t3_sw_v2", issue_valid2, 1'b0);

    // single write so the following fill wraps the pointers
    wr1(addr(5'd9), 32'h500);
    step(); idle();
    step();
    chk1 ("ts_v1", issue_valid1, 1'b1);
    chk32("ts_i1", instruction1, addr(5'd9));
    chk1 ("ts_v2", issue_valid2, 1'b0);
    chk32("ts_pc1", pc1, 32'h500);

    // 4: fill under stall, ready drops, overflow write dropped, then drain
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr2(addr(5'(2*k+1)), addr(5'(2*k+2)), 32'h600 + 32'(8*k));
      step();
      chk1("t4_fill_ready", in_ready, (k < 3) ? 1'b1 : 1'b0);
    end
    chk32("t4_hold_i1", instruction1, addr(5'd9));
    chk1 ("t4_hold_v1", issue_valid1, 1'b1);
    wr2(addr(5'd20), addr(5'd21), 32'h700);
    step();
    chk1("t4_full_ready", in_ready, 1'b0);
    idle(); stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk1 ("t4_drain_v1", issue_valid1, 1'b1);
      chk1 ("t4_drain_v2", issue_valid2, 1'b1);
      chk32("t4_drain_i1", instruction1, addr(5'(2*k+1)));
      chk32("t4_drain_i2", instruction2, addr(5'(2*k+2)));
      chk32("t4_drain_pc1", pc1, 32'h600 + 32'(8*k));
      chk32("t4_drain_pc2", pc2, 32'h604 + 32'(8*k));
      if (k == 0) chk1("t4_ready_back", in_ready, 1'b1);
    end
    step();
    chk1("t4_empty_v1", issue_valid1, 1'b0);

    // 5: flush beats stall and the same-cycle fetch
    wr2(ADD1, ADD2, 32'h700);
    step();
    wr2(addr(5'd3), addr(5'd4), 32'h708);
    step();
    chk1 ("t5_pre_v1", issue_valid1, 1'b1);
    chk32("t5_pre_pc1", pc1, 32'h700);
    flush = 1'b1; stall = 1'b1;
    wr1(addr(5'd5), 32'h800);
    step();
    chk_nop("t5_flush");
    chk1("t5_flush_ready", in_ready, 1'b1);
    flush = 1'b0; stall = 1'b0; idle();
    step();
    chk1("t5_after1_v1", issue_valid1, 1'b0);
    step();
    chk1("t5_after2_v1", issue_valid1, 1'b0);

    // 6: asynchronous reset with the queue half full
    wr2(addr(5'd1), addr(5'd2), 32'h900);
    step();
    wr2(addr(5'd3), addr(5'd4), 32'h908);
    step();
    stall = 1'b1;
    wr2(addr(5'd5), addr(5'd6), 32'h910);
    step();
    chk1 ("t6_pre_v1", issue_valid1, 1'b1);
    chk32("t6_pre_pc1", pc1, 32'h900);
    idle();
    #3 rst = 1'b0;
    #1;
    chk_nop("t6_rst");
    chk1("t6_rst_ready", in_ready, 1'b1);
    rst = 1'b1; stall = 1'b0;
    step();
    chk1("t6_post_v1", issue_valid1, 1'b0);
    step();
    chk1("t6_post2_v1", issue_valid1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
